// File: rtl/audio_pwm_player_if.sv
// rtl/audio_pwm_player_if.sv - instruction stream handshake between buffer chain and audio stage
interface audio_pwm_player_if;
    logic [17:0] instr;
    logic        instr_valid;
    logic        instr_take;

    modport master (output instr, output instr_valid, input instr_take);
    modport slave  (input instr, input instr_valid, output instr_take);
endinterface

// File: rtl/audio_pwm_player.sv
// rtl/audio_pwm_player.sv - audio sample FIFO, sample-rate divider and 8-bit PWM output
module audio_pwm_player #(
    parameter int SAMPLE_DIV = 800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    audio_pwm_player_if.slave    bus,
    output logic                 pwm_out,
    output logic                 underrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TAKE_MAX = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       MIDSCALE = 8'h80;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_cnt_q, next_sample_q, next_sample_d, active_q, active_d;
    logic             pwm_out_q, underrun_q;
    logic             take, tick, pop, empty;

    // Both samples of a word must fit, so a take needs two free entries.
    assign empty          = (count_q == '0);
    assign take           = bus.instr_valid && (bus.instr[17:16] == 2'b11) && (count_q <= TAKE_MAX);
    assign bus.instr_take = take;
    assign tick           = (div_cnt_q == DIV_LAST);
    assign pop            = tick && !empty;
    assign pwm_out        = pwm_out_q;
    assign underrun       = underrun_q;

    always_comb begin
        div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
        wr_ptr_d      = take ? wr_ptr_q + PTR_W'(2) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + (take ? CNT_W'(2) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
        next_sample_d = next_sample_q;
        if (tick) begin
            next_sample_d = empty ? MIDSCALE : mem_q[rd_ptr_q];
        end
        // Duty only changes at the PWM period boundary to avoid glitches.
        active_d      = (pwm_cnt_q == 8'hFF) ? next_sample_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem_q[wr_ptr_q]            <= bus.instr[15:8];
            mem_q[wr_ptr_q + PTR_W'(1)] <= bus.instr[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pwm_cnt_q     <= '0;
            next_sample_q <= MIDSCALE;
            active_q      <= MIDSCALE;
            pwm_out_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pwm_cnt_q     <= pwm_cnt_q + 8'd1;
            next_sample_q <= next_sample_d;
            active_q      <= active_d;
            pwm_out_q     <= (pwm_cnt_q < active_q);
            underrun_q    <= tick && empty;
        end
    end
endmodule

// File: tb/tb_audio_pwm_player.sv
// tb/tb_audio_pwm_player.sv - self-checking bench for audio_pwm_player
module tb_audio_pwm_player;
    localparam int DIV   = 800;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic pwm_out;
    logic underrun;

    audio_pwm_player_if bus_if ();

    audio_pwm_player #(.SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if.slave),
        .pwm_out  (pwm_out),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: cycle count since reset release plus a sample queue.
    int         m_cyc;
    logic [7:0] mq[$];
    logic [7:0] m_next, m_active;
    logic       m_pwm, m_und, m_tick_last;
    int         m_ticks;

    int pwm_diff, und_diff, take_diff;
    int und_seen, take_seen, highs;

    task automatic model_reset();
        m_cyc = 0; mq.delete(); m_next = 8'h80; m_active = 8'h80;
        m_pwm = 1'b0; m_und = 1'b0; m_tick_last = 1'b0;
    endtask

    task automatic step();
        bit         e_take, tick, n_pwm, n_und;
        int         pc;
        logic [7:0] old_next;
        #1;
        e_take = bus_if.instr_valid && (bus_if.instr[17:16] == 2'b11) && (DEPTH - mq.size() >= 2);
        if (bus_if.instr_take !== e_take) take_diff++;
        if (bus_if.instr_take === 1'b1) take_seen++;
        tick     = (m_cyc % DIV) == DIV - 1;
        pc       = m_cyc % 256;
        n_pwm    = pc < int'(m_active);
        n_und    = tick && (mq.size() == 0);
        old_next = m_next;
        if (tick) m_next = (mq.size() > 0) ? mq.pop_front() : 8'h80;
        if (pc == 255) m_active = old_next;
        if (e_take) begin
            mq.push_back(bus_if.instr[15:8]);
            mq.push_back(bus_if.instr[7:0]);
        end
        m_cyc++; m_pwm = n_pwm; m_und = n_und; m_tick_last = tick;
        if (tick) m_ticks++;
        @(posedge clk);
        @(negedge clk);
        if (pwm_out !== m_pwm) pwm_diff++;
        if (underrun !== m_und) und_diff++;
        if (underrun === 1'b1) und_seen++;
        if (pwm_out === 1'b1) highs++;
    endtask

    task automatic step_until_tick();
        int n = 0;
        do begin step(); n++; end while (!m_tick_last && n < 2 * DIV);
        checks++;
        if (!m_tick_last) begin
            errors++;
            $display("FAIL tick_timeout: no tick within %0d cycles, expected one within %0d", n, DIV);
        end
    endtask

    // Ends positioned so the next 256 samples span one full PWM period after the pending sample loads.
    task automatic align_period();
        step();
        while (m_cyc % 256 != 0) step();
        step();
    endtask

    task automatic measure(output int h);
        int h0 = highs;
        repeat (256) step();
        h = highs - h0;
    endtask

    task automatic drive(input logic v, input logic [17:0] w);
        bus_if.instr_valid = v;
        bus_if.instr       = w;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; drive(1'b0, 18'h0);
        model_reset();
        #1;
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        checks++; if (bus_if.instr_take !== 1'b0) begin errors++; $display("FAIL reset_take: got %b expected 0", bus_if.instr_take); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        und_seen = 0;
        repeat (DIV - 1) step();
        checks++; if (und_seen !== 0) begin errors++; $display("FAIL early_underrun: got %0d pulses expected 0", und_seen); end
        step();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL first_underrun: got %b expected 1", underrun); end
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b expected 0", underrun); end
        begin
            int h;
            align_period(); measure(h);
            checks++; if (h !== 128) begin errors++; $display("FAIL idle_duty: got %0d expected 128", h); end
        end
    endtask

    task automatic test_audio();
        int h, u0;
        drive(1'b1, 18'h340C0);
        #1;
        checks++; if (bus_if.instr_take !== 1'b1) begin errors++; $display("FAIL audio_take: got %b expected 1", bus_if.instr_take); end
        step();
        drive(1'b0, 18'h0);
        step();
        checks++; if (take_seen !== 1) begin errors++; $display("FAIL audio_take_once: got %0d expected 1", take_seen); end
        step_until_tick(); align_period(); measure(h);
        checks++; if (h !== 64) begin errors++; $display("FAIL duty_a: got %0d expected 64", h); end
        step_until_tick(); align_period(); measure(h);
        checks++; if (h !== 192) begin errors++; $display("FAIL duty_b: got %0d expected 192", h); end
        u0 = und_seen;
        step_until_tick();
        checks++; if (und_seen - u0 !== 1) begin errors++; $display("FAIL audio_underrun: got %0d expected 1", und_seen - u0); end
        align_period(); measure(h);
        checks++; if (h !== 128) begin errors++; $display("FAIL duty_mid: got %0d expected 128", h); end
    endtask

    task automatic test_nonaudio();
        int u0 = und_seen, t0 = take_seen, k0 = m_ticks;
        drive(1'b1, 18'h01234);
        repeat (2000) step();
        drive(1'b0, 18'h0);
        checks++; if (take_seen - t0 !== 0) begin errors++; $display("FAIL nonaudio_take: got %0d expected 0", take_seen - t0); end
        checks++; if (dut.count_q !== 0) begin errors++; $display("FAIL nonaudio_count: got %0d expected 0", dut.count_q); end
        checks++; if (und_seen - u0 !== m_ticks - k0) begin errors++; $display("FAIL nonaudio_underruns: got %0d expected %0d", und_seen - u0, m_ticks - k0); end
    endtask

    task automatic test_backpressure();
        step_until_tick();
        drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)}); step();
        drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)}); step();
        drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)});
        #1;
        checks++; if (bus_if.instr_take !== 1'b0) begin errors++; $display("FAIL full_take: got %b expected 0", bus_if.instr_take); end
        step_until_tick();
        #1;
        checks++; if (bus_if.instr_take !== 1'b0) begin errors++; $display("FAIL three_take: got %b expected 0", bus_if.instr_take); end
        checks++; if (dut.count_q !== 3) begin errors++; $display("FAIL three_count: got %0d expected 3", dut.count_q); end
        step_until_tick();
        #1;
        checks++; if (bus_if.instr_take !== 1'b1) begin errors++; $display("FAIL two_take: got %b expected 1", bus_if.instr_take); end
        step();
        drive(1'b0, 18'h0);
    endtask

    task automatic test_simultaneous();
        logic [7:0] oldest;
        while (mq.size() != 2) step_until_tick();
        while (m_cyc % DIV != DIV - 1) step();
        drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)});
        oldest = mq[0];
        #1;
        checks++; if (bus_if.instr_take !== 1'b1) begin errors++; $display("FAIL simul_take: got %b expected 1", bus_if.instr_take); end
        step();
        drive(1'b0, 18'h0);
        checks++; if (dut.count_q !== 3) begin errors++; $display("FAIL simul_count: got %0d expected 3", dut.count_q); end
        checks++; if (dut.next_sample_q !== oldest) begin errors++; $display("FAIL simul_pop: got %h expected %h", dut.next_sample_q, oldest); end
        for (int i = 0; i < 8; i++) begin
            if (mq.size() <= 2) begin
                drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)}); step(); drive(1'b0, 18'h0);
            end
            step_until_tick();
            checks++; if (dut.next_sample_q !== m_next) begin errors++; $display("FAIL order_%0d: got %h expected %h", i, dut.next_sample_q, m_next); end
        end
    endtask

    task automatic test_extremes();
        int h;
        while (mq.size() != 0) step_until_tick();
        drive(1'b1, 18'h300FF); step(); drive(1'b0, 18'h0);
        step_until_tick(); align_period(); measure(h);
        checks++; if (h !== 0) begin errors++; $display("FAIL duty_zero: got %0d expected 0", h); end
        step_until_tick(); align_period(); measure(h);
        checks++; if (h !== 255) begin errors++; $display("FAIL duty_full: got %0d expected 255", h); end
        drive(1'b1, {2'b11, 8'($urandom), 8'($urandom)}); step(); drive(1'b0, 18'h0);
        while (m_pwm !== 1'b1) step();
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm: got %b expected 1", pwm_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL async_pwm: got %b expected 0", pwm_out); end
        checks++; if (dut.count_q !== 0) begin errors++; $display("FAIL async_count: got %0d expected 0", dut.count_q); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 18'($urandom));
            step();
        end
        drive(1'b0, 18'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 18'h0);
        pwm_diff = 0; und_diff = 0; take_diff = 0;
        und_seen = 0; take_seen = 0; highs = 0; m_ticks = 0;
        model_reset();
        test_reset();
        test_audio();
        test_nonaudio();
        test_backpressure();
        test_simultaneous();
        test_extremes();
        test_random();
        checks++; if (pwm_diff !== 0) begin errors++; $display("FAIL model_pwm: got %0d differing cycles expected 0", pwm_diff); end
        checks++; if (und_diff !== 0) begin errors++; $display("FAIL model_underrun: got %0d differing cycles expected 0", und_diff); end
        checks++; if (take_diff !== 0) begin errors++; $display("FAIL model_take: got %0d differing cycles expected 0", take_diff); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_pwm_player.md
# audio_pwm_player

Audio output stage for the VGA video player. It consumes audio instructions from the same 18-bit instruction stream that feeds the pixel decoder and buffers the 8-bit samples in a small FIFO. It releases one sample per sample period and drives the PWM audio pin (uio_out[5]) with an 8-bit pulse-width-modulated waveform. It sits beside the pixel decoder, downstream of the QSPI/data-buffer chain.

## Interface
- SAMPLE_DIV, 800, clocks per audio sample; 800 gives one sample per VGA line (~31.47 kHz at 25.175 MHz); must be ≥ 256.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, ≥ 2.

- clk  in  1  pixel clock, ~25 MHz; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  18  instruction word from the buffer chain.
- instr_valid  in  1  instr holds a valid word.
- instr_take  out  1  combinational; word consumed at this rising edge.
- pwm_out  out  1  registered PWM audio output.
- underrun  out  1  registered one-cycle pulse; sample tick found the FIFO empty.

## Operation
- Audio instruction: instr[17:16] == 2'b11.
  - Sample A is instr[15:8]; sample B is instr[7:0]. A plays first.
  - Any other opcode is ignored: instr_take = 0 and FIFO unchanged.
- instr_take = instr_valid & (instr[17:16]==2'b11) & (free ≥ 2), where free = FIFO_DEPTH − count.
  - On a take edge, both samples are written, A then B, and count increases by 2.
  - A partial (single-sample) write is never performed.
- Divider: div_cnt counts 0..SAMPLE_DIV−1 and wraps.
  - tick = (div_cnt == SAMPLE_DIV−1).
- On a tick:
  - FIFO not empty: pop the head into next_sample.
  - FIFO empty: load next_sample = 8'h80 (midscale) and pulse underrun on the next cycle.
- Push and pop on the same edge: both occur, and count changes by +2−1 = +1.
  - instr_take uses count before the edge, so a full-minus-1 FIFO still refuses a take even on a tick cycle.
- PWM: pwm_cnt is an 8-bit free-running counter, 0..255.
  - pwm_out <= (pwm_cnt < active_sample).
  - active_sample <= next_sample only on the edge where pwm_cnt is 255, so the duty cycle changes only at period boundaries (glitch-free).
  - 0x00 gives a constant-low output; 0xFF gives high for 255 of every 256 clocks.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.

## Timing
- Reset (async assert, sync release) sets:
  - div_cnt = 0, pwm_cnt = 0, FIFO empty (count = 0, pointers 0);
  - next_sample = active_sample = 8'h80;
  - pwm_out = 0, underrun = 0.
  - instr_take follows its equation, so it is 0 while the FIFO is empty-reset and instr_valid is low.
- First tick occurs SAMPLE_DIV−1 clocks after reset release.
- Latency from a take edge to audible output:
  - next tick pops A into next_sample;
  - the next pwm_cnt==255 edge moves it to active_sample;
  - pwm_out reflects it from the following edge.
- pwm_out lags pwm_cnt by one clock (registered compare).
- underrun is high for exactly one clock, the cycle after the empty tick.
- Reset mid-stream discards all FIFO contents and returns every output to its reset value immediately (async).

## Test plan
- Reset, no input: pwm_out = 0 and underrun = 0 during reset. Underrun pulses one cycle after the first tick (clock 799 after release). After settling, pwm_out is high 128 of every 256 clocks.
- Push instr = 18'h340C0 with valid high: instr_take = 1 for one cycle. First tick → duty 64/256 from the next PWM period. Second tick → duty 192/256. Third tick → underrun pulse and duty 128/256.
- Non-audio instr = 18'h01234 with valid held high for 2000 clocks: instr_take stays 0, count stays 0, underrun pulses at each tick.
- Full-FIFO backpressure (FIFO_DEPTH = 4): take two audio words (count = 4). A third word sees instr_take = 0. After one tick count = 3 and instr_take is still 0. After the second tick (count = 2) instr_take = 1.
- Simultaneous take and tick with count = 2: count becomes 3 after the edge. The popped value is the oldest sample. FIFO order is preserved over 8 subsequent ticks.
- Extremes and reset: sample 0x00 → pwm_out low for a full 256-clock period. Sample 0xFF → exactly one low clock per period. Asserting rst_n low mid-period forces pwm_out = 0 and count = 0 immediately.
